// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU and the round-robin ALU arbiter.
package alu_pkg;

  localparam int unsigned ALU_W = 8;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    ADD   = 3'b000,
    ADDI  = 3'b001,
    XOR   = 3'b010,
    LOAD  = 3'b011,
    STORE = 3'b100,
    JUMP  = 3'b101,
    CMP   = 3'b110,
    SHF   = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // One captured ALU operation: opcode plus both operands.
  typedef struct packed {
    alu_op_t          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: add, xor, pass, compare and left shift with zero flag.
module alu
  import alu_pkg::*;
(
  input  alu_op_t          op,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  output logic [ALU_W-1:0] result,
  output logic             zero
);

  always_comb begin
    result = '0;
    case (op)
      ADD, ADDI:   result = a + b;
      XOR:         result = a ^ b;
      LOAD, JUMP:  result = a;
      STORE:       result = b;
      CMP:         result = (a == b) ? '0 : ALU_W'(1);
      // Shift amounts of ALU_W or more push every bit out.
      SHF:         result = (b >= ALU_W'(ALU_W)) ? '0 : (a << b);
      default:     result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that sequences N_REQ requesters onto one shared ALU
// and returns tagged, registered results over a valid/ready response channel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [OP_W*N_REQ-1:0]  req_op,
  input  logic [ALU_W*N_REQ-1:0] req_a,
  input  logic [ALU_W*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [ALU_W-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic                   busy
);

  arb_state_t       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  alu_req_t         cap_q, cap_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_fire_c;
  alu_req_t         gnt_req;
  logic [ALU_W-1:0] alu_result;
  logic             alu_zero;

  // First set valid bit at or after ptr, wrapping from N_REQ-1 back to 0.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = ID_W'((32'(ptr) + k) % N_REQ);
      if (!found && valid[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    gnt_idx    = rr_pick(req_valid, ptr_q);
    gnt_fire_c = rst_n && (state_q == IDLE) && (|req_valid);
    req_ready  = gnt_fire_c ? (N_REQ'(1) << gnt_idx) : '0;
  end

  // Steer the granted requester's fields onto one capture bus.
  always_comb begin
    gnt_req = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_req.op = alu_op_t'(req_op[OP_W*i +: OP_W]);
        gnt_req.a  = req_a[ALU_W*i +: ALU_W];
        gnt_req.b  = req_b[ALU_W*i +: ALU_W];
      end
    end
  end

  alu u_alu (
    .op     (cap_q.op),
    .a      (cap_q.a),
    .b      (cap_q.b),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cap_d        = cap_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      IDLE: begin
        if (gnt_fire_c) begin
          state_d = EXEC;
          cap_d   = gnt_req;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end
      end
      EXEC: begin
        state_d      = RESP;
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_id_d     = id_q;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cap_q        <= '0;
      id_q         <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cap_q        <= cap_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_valid_q  <= rsp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign busy       = busy_q;

endmodule
